// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the RAM-side bus of
// the round-robin memory arbiter.
//   Requester port N (N = 0 CPU, 1 DMA):
//     reqN, weN, addrN, wdataN  -> arbiter
//     ackN, rdataN              <- arbiter
//   RAM side:
//     mem_en, mem_we, mem_addr, mem_wdata -> RAM
//     mem_rdata                           <- RAM (valid one cycle after mem_en)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus RAM model)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                  req0,   req1;
    logic                  we0,    we1;
    logic [ADDR_WIDTH-1:0] addr0,  addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  ack0,   ack1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one single-port
// synchronous RAM. Each access walks IDLE -> ISSUE -> CAPTURE, so one access
// completes every three cycles and the winner gets a one-cycle ack together
// with registered read data.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - mem_arbiter_if.slave: both requester ports and the RAM bus
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic                  last_q,      last_d;
    logic                  gnt_q,       gnt_d;
    logic                  we_q,        we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]            ack_q,       ack_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    logic [1:0]            elig;
    logic                  we_in    [2];
    logic [ADDR_WIDTH-1:0] addr_in  [2];
    logic [DATA_WIDTH-1:0] wdata_in [2];

    assign we_in[0]    = bus.we0;
    assign we_in[1]    = bus.we1;
    assign addr_in[0]  = bus.addr0;
    assign addr_in[1]  = bus.addr1;
    assign wdata_in[0] = bus.wdata0;
    assign wdata_in[1] = bus.wdata1;

    // A port that is being acked this cycle is still holding its old request;
    // masking it keeps that stale request from being granted a second time.
    assign elig = {bus.req1, bus.req0} & ~ack_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (elig != 2'b00) begin
                    // On a tie the port that did not win last time goes first.
                    gnt_d       = (elig == 2'b11) ? ~last_q : elig[1];
                    last_d      = gnt_d;
                    we_d        = we_in[gnt_d];
                    mem_addr_d  = addr_in[gnt_d];
                    mem_wdata_d = wdata_in[gnt_d];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                ack_d[gnt_q] = 1'b1;
                if (!we_q) begin
                    rdata_d[gnt_q] = bus.mem_rdata;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= 2'b00;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
        end
    end

    // The RAM is only ever enabled for the single ISSUE cycle of an access.
    assign bus.mem_en    = (state_q == S_ISSUE);
    assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.rdata0    = rdata_q[0];
    assign bus.rdata1    = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Holds a RAM model on
// the memory side, drives both requester ports, and checks results against a
// reference memory image updated in ack order.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM seen by the arbiter: registered read, write on mem_en & mem_we
    logic [DW-1:0] ram [65536];
    logic [DW-1:0] rd_q;
    logic          ram_init;
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    assign bus.mem_rdata = rd_q;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 7) ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= ram[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: memory image and the last read value per port
    logic [DW-1:0] model_mem [65536];
    logic [DW-1:0] exp_rd [2];
    int checks = 0;
    int errors = 0;

    task automatic idle_inputs();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_en = 1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 0;
        model_mem[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Issue one access on port p and wait (bounded) for its ack.
    // Returns the number of negedges until ack was seen, or ok=0 on timeout.
    task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output bit ok,
                          output logic [DW-1:0] rd);
        ok = 0; lat = 0; rd = '0;
        @(negedge clk);
        if (p == 0) begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
        else        begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) begin
                ok = 1; lat = t;
                rd = (p == 0) ? bus.rdata0 : bus.rdata1;
                break;
            end
        end
        if (p == 0) bus.req0 = 0; else bus.req1 = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0)
            begin errors++; $display("FAIL reset_outputs: got ack=%b%b en=%b we=%b addr=%h wd=%h rd0=%h rd1=%h required all zero",
                bus.ack1, bus.ack0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1); end
        reset = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic test_single_read();
        poke(16'h0010, 16'hBEEF);
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0010)
            begin errors++; $display("FAIL single_issue: got en=%b we=%b addr=%h required en=1 we=0 addr=0010",
                bus.mem_en, bus.mem_we, bus.mem_addr); end
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.ack0 !== 1'b0)
            begin errors++; $display("FAIL single_capture: got en=%b ack0=%b required 0 0", bus.mem_en, bus.ack0); end
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 16'hBEEF || bus.ack1 !== 1'b0)
            begin errors++; $display("FAIL single_ack: got ack0=%b rdata0=%h ack1=%b required 1 beef 0",
                bus.ack0, bus.rdata0, bus.ack1); end
        exp_rd[0] = 16'hBEEF;
        bus.req0 = 0;
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b0)
            begin errors++; $display("FAIL single_ack_pulse: got ack0=%b required 0", bus.ack0); end
    endtask

    task automatic test_write_read_p1();
        int lat; bit ok; logic [DW-1:0] rd;
        @(negedge clk);
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0020; bus.wdata1 = 16'h1234;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 16'h1234)
            begin errors++; $display("FAIL write_issue: got en=%b we=%b addr=%h wd=%h required 1 1 0020 1234",
                bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.rdata1 !== exp_rd[1])
            begin errors++; $display("FAIL write_ack: got ack1=%b ack0=%b rdata1=%h required 1 0 %h",
                bus.ack1, bus.ack0, bus.rdata1, exp_rd[1]); end
        model_mem[16'h0020] = 16'h1234;
        bus.req1 = 0;
        access(1, 1'b0, 16'h0020, 16'h0000, lat, ok, rd);
        checks++;
        if (!ok || rd !== 16'h1234 || lat != 3)
            begin errors++; $display("FAIL write_readback: got ok=%0d lat=%0d rdata1=%h required 1 3 1234", ok, lat, rd); end
        exp_rd[1] = 16'h1234;
    endtask

    task automatic test_tie();
        int c0, c1; bit ovl;
        c0 = -1; c1 = -1; ovl = 0;
        do_reset();
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0030;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0031;
        for (int t = 0; t < 20 && (c0 < 0 || c1 < 0); t++) begin
            @(negedge clk);
            if (bus.ack0 && bus.ack1) ovl = 1;
            if (bus.ack0) begin
                c0 = cyc; bus.req0 = 0;
                checks++;
                if (bus.rdata0 !== model_mem[16'h0030])
                    begin errors++; $display("FAIL tie_rdata0: got %h required %h", bus.rdata0, model_mem[16'h0030]); end
                exp_rd[0] = model_mem[16'h0030];
            end
            if (bus.ack1) begin
                c1 = cyc; bus.req1 = 0;
                checks++;
                if (bus.rdata1 !== model_mem[16'h0031])
                    begin errors++; $display("FAIL tie_rdata1: got %h required %h", bus.rdata1, model_mem[16'h0031]); end
                exp_rd[1] = model_mem[16'h0031];
            end
        end
        idle_inputs();
        checks++;
        if (c0 < 0 || c1 < 0 || ovl || (c1 - c0) != 3)
            begin errors++; $display("FAIL tie_order: got ack0@%0d ack1@%0d overlap=%0d required ack1 3 cycles after ack0",
                c0, c1, ovl); end
    endtask

    // Random/structured traffic on both ports, scoreboarded in ack order.
    // spacing != 0 requires consecutive acks exactly that many cycles apart;
    // alt requires consecutive acks to come from alternating ports.
    task automatic run_traffic(input string nm, input int n0, input int n1, input int gap,
                               input int spacing, input bit alt, input bit seq);
        int left [2]; bit pend [2]; logic rw [2];
        logic [AW-1:0] ra [2]; logic [DW-1:0] rwd [2];
        bit ackv [2]; logic [DW-1:0] rdv [2]; logic [DW-1:0] ex;
        int prev_cyc, prev_p, nseq;
        left[0] = n0; left[1] = n1; pend[0] = 0; pend[1] = 0;
        rw[0] = 0; rw[1] = 0; ra[0] = '0; ra[1] = '0; rwd[0] = '0; rwd[1] = '0;
        prev_cyc = -1; prev_p = -1; nseq = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            ackv[0] = bus.ack0; ackv[1] = bus.ack1;
            rdv[0] = bus.rdata0; rdv[1] = bus.rdata1;
            if (ackv[0] || ackv[1]) begin
                checks++;
                if (ackv[0] && ackv[1])
                    begin errors++; $display("FAIL %s_overlap: got ack0=1 ack1=1 at cycle %0d required one-hot", nm, cyc); end
            end
            for (int p = 0; p < 2; p++) begin
                if (ackv[p]) begin
                    checks++;
                    if (!pend[p]) begin
                        errors++; $display("FAIL %s_spurious_ack%0d: got ack with no request required none", nm, p);
                    end else begin
                        if (rw[p]) begin model_mem[ra[p]] = rwd[p]; ex = exp_rd[p]; end
                        else       begin ex = model_mem[ra[p]]; exp_rd[p] = ex; end
                        if (rdv[p] !== ex)
                            begin errors++; $display("FAIL %s_rdata%0d: got %h required %h (addr %h we %b)",
                                nm, p, rdv[p], ex, ra[p], rw[p]); end
                        if (spacing != 0 && prev_cyc >= 0) begin
                            checks++;
                            if (cyc - prev_cyc != spacing)
                                begin errors++; $display("FAIL %s_spacing: got %0d cycles required %0d", nm, cyc - prev_cyc, spacing); end
                        end
                        if (alt && prev_p >= 0) begin
                            checks++;
                            if (p == prev_p)
                                begin errors++; $display("FAIL %s_alternation: got port %0d twice required alternating", nm, p); end
                        end
                        prev_cyc = cyc; prev_p = p; pend[p] = 0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && left[p] > 0 && $urandom_range(0, gap) == 0) begin
                    pend[p] = 1; left[p]--;
                    if (seq) begin
                        nseq++; rw[p] = 0; ra[p] = AW'(nseq); rwd[p] = '0;
                    end else begin
                        rw[p] = 1'($urandom_range(0, 1)); ra[p] = AW'($urandom_range(0, 15));
                        rwd[p] = DW'($urandom);
                    end
                end
            end
            bus.req0 = pend[0]; bus.we0 = rw[0]; bus.addr0 = ra[0]; bus.wdata0 = rwd[0];
            bus.req1 = pend[1]; bus.we1 = rw[1]; bus.addr1 = ra[1]; bus.wdata1 = rwd[1];
            if (left[0] == 0 && left[1] == 0 && !pend[0] && !pend[1]) break;
        end
        checks++;
        if (pend[0] || pend[1] || left[0] != 0 || left[1] != 0)
            begin errors++; $display("FAIL %s_timeout: got outstanding=%0d/%0d required all served", nm,
                left[0] + int'(pend[0]), left[1] + int'(pend[1])); end
        idle_inputs();
    endtask

    task automatic test_contention();
        repeat (2) @(negedge clk);
        run_traffic("contention", 6, 6, 0, 3, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        run_traffic("b2b", 3, 0, 0, 4, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        repeat (2) @(negedge clk);
        run_traffic("random", 20, 20, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_issue();
        int first; bit got0, got1;
        first = -1; got0 = 0; got1 = 0;
        repeat (2) @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0055;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0055)
            begin errors++; $display("FAIL rst_issue_pre: got en=%b addr=%h required 1 0055", bus.mem_en, bus.mem_addr); end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_en, bus.mem_we,
             bus.mem_addr, bus.mem_wdata} !== '0)
            begin errors++; $display("FAIL rst_issue_outputs: got ack=%b%b en=%b addr=%h rd0=%h rd1=%h required all zero",
                bus.ack1, bus.ack0, bus.mem_en, bus.mem_addr, bus.rdata0, bus.rdata1); end
        reset = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        // port 1 joins right away: a restored last pointer lets port 0 win the tie
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0056;
        for (int t = 0; t < 20 && !(got0 && got1); t++) begin
            @(negedge clk);
            if (bus.ack0) begin
                if (first < 0) first = 0;
                got0 = 1; bus.req0 = 0;
                checks++;
                if (bus.rdata0 !== model_mem[16'h0055])
                    begin errors++; $display("FAIL rst_reissue_rdata0: got %h required %h", bus.rdata0, model_mem[16'h0055]); end
                exp_rd[0] = model_mem[16'h0055];
            end
            if (bus.ack1) begin
                if (first < 0) first = 1;
                got1 = 1; bus.req1 = 0;
                exp_rd[1] = model_mem[16'h0056];
            end
        end
        idle_inputs();
        checks++;
        if (!got0 || !got1 || first != 0)
            begin errors++; $display("FAIL rst_reissue_order: got ack0=%0d ack1=%0d first=%0d required both, port 0 first",
                got0, got1, first); end
    endtask

    initial begin
        reset = 1;
        ram_init = 1; poke_en = 0; poke_addr = '0; poke_data = '0;
        idle_inputs();
        for (int i = 0; i < 65536; i++) model_mem[i] = pat(i);
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        ram_init = 0;
        test_reset();
        test_single_read();
        test_write_read_p1();
        test_tie();
        test_contention();
        test_reset_in_issue();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
